// File: rtl/gmm_seq_pkg.sv
// gmm_seq_pkg
// Shared definitions for the GMM frame sequencer: sequencer state encoding,
// default geometry constants, error-bit positions and a saturating counter
// helper. Imported by gmm_inflight_counter and gmm_frame_sequencer.
package gmm_seq_pkg;

  localparam int NUM_PIXEL_DEF = 76800;
  localparam int ADDR_W_DEF    = 18;
  localparam int MAX_OUT_DEF   = 8;

  // Positions inside the sticky err_o vector
  localparam int ERR_SOP_MID   = 0;
  localparam int ERR_UNDERFLOW = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } seq_state_e;

  // Frame counter increments stick at all-ones instead of wrapping
  function automatic logic [15:0] sat_inc16(input logic [15:0] value);
    if (value == 16'hFFFF) begin
      return value;
    end else begin
      return value + 16'd1;
    end
  endfunction

endpackage

// File: rtl/gmm_inflight_counter.sv
// gmm_inflight_counter
// Up/down occupancy counter for pixels in flight between launch and
// completion. Increment and decrement in the same cycle cancel. A decrement
// while empty is dropped and reported as a one-cycle underflow pulse; an
// increment while full (without a matching decrement) is dropped.
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   inc, dec   increment / decrement requests
//   count      current occupancy (registered)
//   empty      count == 0
//   full       count == MAX
//   underflow  dec requested while empty (combinational pulse)
module gmm_inflight_counter
  import gmm_seq_pkg::*;
#(
  parameter int MAX = MAX_OUT_DEF,
  parameter int W   = $clog2(MAX + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         empty,
  output logic         full,
  output logic         underflow
);

  logic dec_ok;
  logic inc_ok;

  assign empty     = (count == '0);
  assign full      = (count == W'(MAX));
  assign underflow = dec & empty;
  assign dec_ok    = dec & ~empty;
  // A full counter can still accept an increment if a decrement frees a slot
  assign inc_ok    = inc & (~full | dec_ok);

  // Occupancy register
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (inc_ok && !dec_ok) begin
      count <= count + W'(1);
    end else if (dec_ok && !inc_ok) begin
      count <= count - W'(1);
    end else begin
      count <= count;
    end
  end

endmodule

// File: rtl/gmm_frame_sequencer.sv
// gmm_frame_sequencer
// Pops grey pixels from the input FIFO and launches them into fitgaussian
// with the matching parameter-memory read address, tracks pixels in flight,
// produces the write-back address and frame markers on completion, counts
// completed frames and recovers from a start-of-frame arriving mid-frame by
// draining the pipeline and relaunching that pixel as pixel 0.
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   pix_valid_i, pix_sop_i  input FIFO head valid / head is start of frame
//   pix_ready_o             pop the head pixel (combinational)
//   out_afull_i             output FIFO almost full, blocks launches
//   fit_en_o, raddr_o,
//   first_frame_o           launch pulse, read address, frame-0 flag
//                           (registered, one cycle after the handshake)
//   fit_done_i              in-order completion pulse
//   waddr_o, out_sop_o,
//   out_eop_o               write address and frame markers for the
//                           completing pixel (combinational)
//   frame_cnt_o             completed frames, saturating
//   err_o                   sticky errors: [0] SOP mid-frame,
//                           [1] completion with nothing in flight
module gmm_frame_sequencer
  import gmm_seq_pkg::*;
#(
  parameter int NUM_PIXEL = NUM_PIXEL_DEF,
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int MAX_OUT   = MAX_OUT_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              pix_valid_i,
  input  logic              pix_sop_i,
  output logic              pix_ready_o,
  input  logic              out_afull_i,
  output logic              fit_en_o,
  output logic [ADDR_W-1:0] raddr_o,
  output logic              first_frame_o,
  input  logic              fit_done_i,
  output logic [ADDR_W-1:0] waddr_o,
  output logic              out_sop_o,
  output logic              out_eop_o,
  output logic [15:0]       frame_cnt_o,
  output logic [1:0]        err_o
);

  localparam int                OW   = $clog2(MAX_OUT + 1);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_PIXEL - 1);

  seq_state_e        state;
  logic [ADDR_W-1:0] lcnt;
  logic [ADDR_W-1:0] wcnt;
  // Set when the current frame launched its last pixel; decides whether the
  // drain that follows counts as a completed frame
  logic              frame_full;

  logic [OW-1:0]     outst;
  logic              out_empty;
  logic              out_full;
  logic              underflow;

  logic              ready;
  logic              sop_abort;
  logic              handshake;
  logic              launch;
  logic              done_ok;

  // Pop permission and mid-frame SOP detection
  always_comb begin
    ready     = 1'b0;
    sop_abort = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
      end
      RUN: begin
        // A new frame start while mid-frame is held at the FIFO head
        if (pix_valid_i && pix_sop_i && (lcnt != '0)) begin
          sop_abort = 1'b1;
          ready     = 1'b0;
        end else begin
          ready = ~out_afull_i & ~out_full;
        end
      end
      DRAIN: begin
        ready = 1'b0;
      end
      default: begin
        ready = 1'b0;
      end
    endcase
  end

  assign pix_ready_o = ready;
  assign handshake   = pix_valid_i & ready;
  // In IDLE only a start-of-frame pixel is launched; the rest are discarded
  assign launch      = handshake & ((state != IDLE) | pix_sop_i);
  // Completions with nothing in flight are ignored everywhere
  assign done_ok     = fit_done_i & ~out_empty;

  assign waddr_o     = wcnt;
  assign out_sop_o   = done_ok & (wcnt == '0);
  assign out_eop_o   = done_ok & (wcnt == LAST);

  gmm_inflight_counter #(
    .MAX (MAX_OUT),
    .W   (OW)
  ) u_outst (
    .clk       (clk_i),
    .rst       (rst_i),
    .inc       (launch),
    .dec       (fit_done_i),
    .count     (outst),
    .empty     (out_empty),
    .full      (out_full),
    .underflow (underflow)
  );

  // Sequencer FSM, launch registers, write counter, frame counter and errors
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state         <= IDLE;
      lcnt          <= '0;
      wcnt          <= '0;
      frame_full    <= 1'b0;
      fit_en_o      <= 1'b0;
      raddr_o       <= '0;
      first_frame_o <= 1'b0;
      frame_cnt_o   <= 16'd0;
      err_o         <= 2'b00;
    end else begin
      fit_en_o <= launch;
      if (launch) begin
        raddr_o       <= lcnt;
        first_frame_o <= (frame_cnt_o == 16'd0);
      end

      if (underflow) begin
        err_o[ERR_UNDERFLOW] <= 1'b1;
      end
      if (sop_abort) begin
        err_o[ERR_SOP_MID] <= 1'b1;
      end

      if (done_ok) begin
        wcnt <= (wcnt == LAST) ? '0 : wcnt + ADDR_W'(1);
      end

      case (state)
        IDLE: begin
          if (launch) begin
            lcnt       <= ADDR_W'(1);
            frame_full <= 1'b0;
            state      <= RUN;
          end
        end
        RUN: begin
          if (sop_abort) begin
            frame_full <= 1'b0;
            state      <= DRAIN;
          end else if (launch) begin
            if (lcnt == LAST) begin
              lcnt       <= '0;
              frame_full <= 1'b1;
              state      <= DRAIN;
            end else begin
              lcnt <= lcnt + ADDR_W'(1);
            end
          end
        end
        DRAIN: begin
          // Restart only once the pipeline is empty and quiet
          if ((outst == '0) && !fit_done_i) begin
            lcnt <= '0;
            wcnt <= '0;
            if (frame_full) begin
              frame_cnt_o <= sat_inc16(frame_cnt_o);
            end
            frame_full <= 1'b0;
            state      <= RUN;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
